fpga2_receiver: RTL and testbench
=================================

# fpga2_receiver

Receive-side link stage on FPGA 2, directly downstream of the FPGA 1 sender. Accepts a burst of 32-bit words under the req/rdy handshake, buffers them in a local 512-word FIFO, checks the received word count against the expected count when `send_done_in` arrives, and then either ACKs (commits the burst) or NACKs (discards it and forces a resend). Only committed bursts are visible to the downstream process through the read port.

## Interface
- `DATA_W`, 32, word width
- `ADDR_W`, 9, FIFO address width (depth = 2^ADDR_W = 512)
- `COUNT_W`, 10, burst length width
- `NACK_CYCLES`, 4, cycles `rdy_out` is held low on NACK

- `clk` in 1: single clock; reset is asynchronous and active-low
- `rst_n` in 1: asynchronous active-low reset
- `req_in` in 1: request from the sender
- `valid_in` in 1: `data_in` holds a word this cycle
- `data_in` in DATA_W: word from the sender
- `send_done_in` in 1: end-of-burst marker, stretched 1–3 cycles
- `exp_count` in COUNT_W: expected words per burst, from the local process
- `rdy_out` out 1: ready to the sender
- `ack_out` out 1: acknowledge to the sender
- `rd_en_i` in 1: consumer read request
- `rd_data_o` out DATA_W: read data
- `empty_o` out 1: no committed words
- `level_o` out ADDR_W+1: committed word count
- `underflow_o` out 1: one-cycle pulse on a read while empty
- `ack_cnt_o` out 16: ACKed bursts (see Configuration)
- `nack_cnt_o` out 16: NACKed bursts (see Configuration)

## Operation
Pointers:
- `wr_ptr` is the speculative write pointer.
- `commit_ptr` is the last committed position.
- `rd_ptr` is the read pointer.
- All pointers are ADDR_W+1 bits wide and wrap modulo 2^(ADDR_W+1).
- free = 2^ADDR_W − (`wr_ptr` − `rd_ptr`).

State machine: IDLE, RECEIVE, CHECK, ACK, NACK.
- **IDLE**
  - `rdy_out`=0, `ack_out`=0.
  - If `req_in`=1, `exp_count`≠0 and free ≥ `exp_count`: latch `exp_q`=`exp_count`, clear `rx_cnt` and `ovr`, go to RECEIVE.
  - If `exp_count`=0, or free < `exp_count`, stay in IDLE.
- **RECEIVE**
  - `rdy_out`=1.
  - Word accept: on `valid_in`=1 with `rx_cnt`<`exp_q`, write `data_in` at `wr_ptr`, then increment `wr_ptr` and `rx_cnt`.
  - Overrun: on `valid_in`=1 with `rx_cnt`=`exp_q`, drop the word and set `ovr`.
  - Rising edge of `send_done_in` (registered edge detect): go to CHECK. If a word arrives in that same cycle, it is accepted first.
  - `req_in`=0 before `send_done_in`: abort. Set `wr_ptr`←`commit_ptr` and go to IDLE.
- **CHECK** (1 cycle, `rdy_out`=1)
  - If `rx_cnt`=`exp_q` and !`ovr`: set `commit_ptr`←`wr_ptr` and go to ACK.
  - Otherwise: set `wr_ptr`←`commit_ptr` and go to NACK.
- **ACK**
  - `ack_out`=1 and `rdy_out`=1, held until `req_in`=0, then go to IDLE.
- **NACK**
  - `rdy_out`=0, `ack_out`=0 for NACK_CYCLES cycles, then go to IDLE.
  - The sender sees `rdy_in` low, resends, and re-raises req; IDLE then re-arms.

Read side:
- `rd_en_i`=1 with !`empty_o`: `rd_data_o`←mem[`rd_ptr`], then increment `rd_ptr`.
- `rd_en_i`=1 while `empty_o`=1: ignored, and `underflow_o` pulses.
- `empty_o` = (`commit_ptr`=`rd_ptr`). `level_o` = `commit_ptr`−`rd_ptr`.
- A read in the same cycle as a commit uses the pre-commit `commit_ptr`.

Reset (async assert, sync deassert edge):
- All pointers, `rx_cnt` and counters reset to 0; state goes to IDLE.
- `rdy_out`=0, `ack_out`=0, `empty_o`=1, `level_o`=0, `underflow_o`=0, `rd_data_o`=0.
- Mid-burst reset discards all data, including committed data.

## Timing
- `rdy_out` rises 1 cycle after `req_in` is sampled high in IDLE with sufficient space.
- Written words are invisible to the reader until commit.
- `empty_o` falls 1 cycle after the CHECK cycle.
- `send_done_in` rising edge at cycle N: CHECK at N+1; `ack_out`=1 or `rdy_out`=0 at N+2.
- Read latency: `rd_data_o` is valid 1 cycle after `rd_en_i`.
- Back-to-back reads: one word per cycle.
- Space check happens only at IDLE→RECEIVE, so a burst never overflows the FIFO.

## Configuration
- `FPGA2_RX_STATS_EN` defined:
  - `ack_cnt_o` increments on each CHECK→ACK.
  - `nack_cnt_o` increments on each CHECK→NACK.
  - Both are 16-bit, saturate at 0xFFFF, and clear on reset.
- Not defined: both outputs are tied to 0 and no counter logic is synthesised.

## Test plan
- **Clean burst:** `exp_count`=4, req, 4 valid words 0xA0..0xA3, then `send_done_in` for 3 cycles → single ACK, `level_o`=4, reads return 0xA0..0xA3 in order, then `empty_o`=1.
- **Short burst:** `exp_count`=4, only 3 words → NACK, `rdy_out` low 4 cycles, `level_o` stays 0. Resend of 4 words → ACK, `level_o`=4.
- **Overrun:** `exp_count`=2, 3 words → NACK, `level_o`=0, `nack_cnt_o`=1 with the macro defined, 0 without.
- **Space gating:** with 510 committed words and `exp_count`=4, `rdy_out` stays 0. After 2 reads, `rdy_out` rises; burst → ACK, `level_o`=512.
- **Abort:** `req_in` drops after 2 of 4 words → IDLE, `wr_ptr`=`commit_ptr`, `level_o` unchanged, no ACK.
- **Reset:** `rst_n` asserted during RECEIVE with 10 committed words → all outputs at reset values immediately; after release, `empty_o`=1 and a new burst succeeds.

Source files
------------

// File: rtl/fpga2_receiver.sv
// Receive-side link stage: buffers a burst in a 512-word FIFO, ACKs or NACKs it on send_done.
// Optional saturating ACK/NACK statistics are enabled with `define FPGA2_RX_STATS_EN.
module fpga2_receiver #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned COUNT_W     = 10,
  parameter int unsigned NACK_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_in,
  input  logic                valid_in,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                send_done_in,
  input  logic [COUNT_W-1:0]  exp_count,
  output logic                rdy_out,
  output logic                ack_out,
  input  logic                rd_en_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                empty_o,
  output logic [ADDR_W:0]     level_o,
  output logic                underflow_o,
  output logic [15:0]         ack_cnt_o,
  output logic [15:0]         nack_cnt_o
);

  localparam int unsigned PtrW  = ADDR_W + 1;
  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CmpW  = ((PtrW > COUNT_W) ? PtrW : COUNT_W) + 1;
  localparam int unsigned WaitW = $clog2(NACK_CYCLES) + 1;

  typedef enum logic [2:0] {StIdle, StReceive, StCheck, StAck, StNack} state_e;

  state_e              r_state, w_state_next;
  logic [PtrW-1:0]     r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic [COUNT_W-1:0]  r_exp, r_rx_cnt;
  logic                r_ovr, r_done_q, r_underflow;
  logic [WaitW-1:0]    r_wait;
  logic [DATA_W-1:0]   r_rd_data;
  logic [DATA_W-1:0]   r_mem [Depth];

  logic [PtrW-1:0]     w_free;
  logic                w_start, w_done_rise, w_accept, w_empty, w_rd, w_pass, w_nack_last;

  // Space is checked only here, so an admitted burst can never overflow the FIFO.
  assign w_free      = PtrW'(Depth) - (r_wr_ptr - r_rd_ptr);
  assign w_start     = req_in && (exp_count != '0) && (CmpW'(w_free) >= CmpW'(exp_count));
  assign w_done_rise = send_done_in && !r_done_q;
  assign w_accept    = (r_state == StReceive) && valid_in && (r_rx_cnt < r_exp);
  assign w_empty     = (r_commit_ptr == r_rd_ptr);
  assign w_rd        = rd_en_i && !w_empty;
  assign w_pass      = (r_rx_cnt == r_exp) && !r_ovr;
  assign w_nack_last = (r_wait == WaitW'(NACK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (w_start) w_state_next = StReceive;
      StReceive: begin
        if (w_done_rise)  w_state_next = StCheck;
        else if (!req_in) w_state_next = StIdle;
      end
      StCheck:   w_state_next = w_pass ? StAck : StNack;
      StAck:     if (!req_in) w_state_next = StIdle;
      StNack:    if (w_nack_last) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    rdy_out = 1'b0;
    ack_out = 1'b0;
    case (r_state)
      StReceive, StCheck: rdy_out = 1'b1;
      StAck: begin
        rdy_out = 1'b1;
        ack_out = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_exp        <= '0;
      r_rx_cnt     <= '0;
      r_ovr        <= 1'b0;
      r_done_q     <= 1'b0;
      r_wait       <= '0;
      r_rd_data    <= '0;
      r_underflow  <= 1'b0;
    end else begin
      r_done_q    <= send_done_in;
      r_underflow <= rd_en_i && w_empty;
      if (w_rd) begin
        r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
        r_rd_ptr  <= r_rd_ptr + PtrW'(1);
      end
      case (r_state)
        StIdle: if (w_start) begin
          r_exp    <= exp_count;
          r_rx_cnt <= '0;
          r_ovr    <= 1'b0;
        end
        StReceive: begin
          if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + PtrW'(1);
            r_rx_cnt <= r_rx_cnt + COUNT_W'(1);
          end else if (valid_in) begin
            r_ovr <= 1'b1;
          end
          // Abort rolls back the speculative writes.
          if (!w_done_rise && !req_in) r_wr_ptr <= r_commit_ptr;
        end
        StCheck: begin
          if (w_pass) r_commit_ptr <= r_wr_ptr;
          else        r_wr_ptr     <= r_commit_ptr;
          r_wait <= '0;
        end
        StNack:  r_wait <= r_wait + WaitW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr[ADDR_W-1:0]] <= data_in;
  end

  assign rd_data_o   = r_rd_data;
  assign empty_o     = w_empty;
  assign level_o     = r_commit_ptr - r_rd_ptr;
  assign underflow_o = r_underflow;

`ifdef FPGA2_RX_STATS_EN
  logic [15:0] r_ack_cnt, r_nack_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_cnt  <= '0;
      r_nack_cnt <= '0;
    end else if (r_state == StCheck) begin
      if (w_pass) begin
        if (r_ack_cnt != 16'hFFFF) r_ack_cnt <= r_ack_cnt + 16'd1;
      end else begin
        if (r_nack_cnt != 16'hFFFF) r_nack_cnt <= r_nack_cnt + 16'd1;
      end
    end
  end

  assign ack_cnt_o  = r_ack_cnt;
  assign nack_cnt_o = r_nack_cnt;
`else
  assign ack_cnt_o  = '0;
  assign nack_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fpga2_receiver.sv
// Randomized bench for fpga2_receiver against a queue-based model of committed bursts.
module tb_fpga2_receiver;

  localparam int NackCycles = 4;

  logic        clk, rst_n, req_in, valid_in, send_done_in, rd_en_i;
  logic [31:0] data_in, rd_data_o;
  logic [9:0]  exp_count, level_o;
  logic        rdy_out, ack_out, empty_o, underflow_o;
  logic [15:0] ack_cnt_o, nack_cnt_o;

  fpga2_receiver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_in       (req_in),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .send_done_in (send_done_in),
    .exp_count    (exp_count),
    .rdy_out      (rdy_out),
    .ack_out      (ack_out),
    .rd_en_i      (rd_en_i),
    .rd_data_o    (rd_data_o),
    .empty_o      (empty_o),
    .level_o      (level_o),
    .underflow_o  (underflow_o),
    .ack_cnt_o    (ack_cnt_o),
    .nack_cnt_o   (nack_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model_q[$];
  int          exp_acks, exp_nacks, done_left;
  int          n_checks, n_pass;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (done_left > 0) begin
      done_left--;
      send_done_in = (done_left > 0);
    end
  endtask

  task automatic check_stats();
`ifdef FPGA2_RX_STATS_EN
    check_eq("ack_cnt", 32'(ack_cnt_o), exp_acks);
    check_eq("nack_cnt", 32'(nack_cnt_o), exp_nacks);
`else
    check_eq("ack_cnt", 32'(ack_cnt_o), 0);
    check_eq("nack_cnt", 32'(nack_cnt_o), 0);
`endif
  endtask

  // Sends n words against expected count e; base < 0 selects random data.
  task automatic burst(input int e, input int n, input bit abort, input int base);
    logic [31:0] sent[$];
    int          guard, len;
    bit          merge;
    guard = 0;
    len   = 1 + int'($urandom_range(0, 2));
    merge = $urandom_range(0, 1) == 1;
    exp_count = 10'(e);
    req_in    = 1'b1;
    step();
    while (!rdy_out && guard < 20) begin
      step();
      guard++;
    end
    check_eq("rdy_latency", guard, 0);
    for (int i = 0; i < n; i++) begin
      if (abort && i == 2) break;
      if ($urandom_range(0, 3) == 0) begin
        valid_in = 1'b0;
        step();
      end
      valid_in = 1'b1;
      data_in  = (base < 0) ? $urandom : 32'(base + i);
      sent.push_back(data_in);
      if (merge && !abort && i == n - 1) begin
        send_done_in = 1'b1;
        done_left    = len;
      end
      step();
    end
    valid_in = 1'b0;
    if (abort) begin
      req_in = 1'b0;
      step();
      check_eq("abort_rdy", 32'(rdy_out), 0);
      check_eq("abort_ack", 32'(ack_out), 0);
      check_eq("abort_level", 32'(level_o), model_q.size());
      return;
    end
    if (!merge) begin
      send_done_in = 1'b1;
      done_left    = len;
      step();
    end
    check_eq("check_rdy", 32'(rdy_out), 1);
    check_eq("check_ack", 32'(ack_out), 0);
    check_eq("check_level", 32'(level_o), model_q.size());
    step();
    if (n == e) begin
      foreach (sent[i]) model_q.push_back(sent[i]);
      exp_acks++;
      check_eq("ack_out", 32'(ack_out), 1);
      check_eq("ack_level", 32'(level_o), model_q.size());
      check_eq("ack_empty", 32'(empty_o), 0);
      req_in = 1'b0;
      step();
      check_eq("ack_drop", 32'(ack_out), 0);
    end else begin
      exp_nacks++;
      req_in = 1'b0;
      for (int k = 0; k < NackCycles; k++) begin
        check_eq("nack_rdy", 32'(rdy_out), 0);
        check_eq("nack_ack", 32'(ack_out), 0);
        step();
      end
      check_eq("nack_level", 32'(level_o), model_q.size());
    end
    check_stats();
  endtask

  task automatic do_reads(input int n);
    logic [31:0] want;
    for (int i = 0; i < n; i++) begin
      rd_en_i = 1'b1;
      step();
      if (model_q.size() > 0) begin
        want = model_q.pop_front();
        check_eq("rd_data", rd_data_o, want);
        check_eq("no_underflow", 32'(underflow_o), 0);
      end else begin
        check_eq("underflow", 32'(underflow_o), 1);
      end
      check_eq("rd_level", 32'(level_o), model_q.size());
      check_eq("rd_empty", 32'(empty_o), 32'(model_q.size() == 0));
    end
    rd_en_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e, mode, n;
    n_checks = 0; n_pass = 0; exp_acks = 0; exp_nacks = 0; done_left = 0;
    rst_n = 1'b0; req_in = 1'b0; valid_in = 1'b0; data_in = '0;
    send_done_in = 1'b0; exp_count = '0; rd_en_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check_eq("rst_rdy", 32'(rdy_out), 0);
    check_eq("rst_ack", 32'(ack_out), 0);
    check_eq("rst_empty", 32'(empty_o), 1);
    check_eq("rst_level", 32'(level_o), 0);
    check_eq("rst_rd_data", rd_data_o, 0);
    check_stats();

    // Directed cases
    burst(4, 4, 1'b0, 32'hA0);
    do_reads(5);
    burst(4, 3, 1'b0, -1);
    burst(4, 4, 1'b0, -1);
    burst(2, 3, 1'b0, -1);
    burst(4, 4, 1'b1, -1);
    burst(3, 3, 1'b0, -1);
    do_reads(8);

    // Randomized bursts interleaved with reads
    for (int it = 0; it < 16; it++) begin
      e    = 1 + int'($urandom_range(0, 7));
      mode = int'($urandom_range(0, 3));
      if (mode == 1 && e > 1)      burst(e, e - 1, 1'b0, -1);
      else if (mode == 2)          burst(e, e + 1 + int'($urandom_range(0, 1)), 1'b0, -1);
      else if (mode == 3 && e > 2) burst(e, e, 1'b1, -1);
      else                         burst(e, e, 1'b0, -1);
      do_reads(int'($urandom_range(0, 6)));
    end
    do_reads(model_q.size() + 1);

    // Space gating: 510 committed words leave no room for a 4-word burst
    burst(510, 510, 1'b0, -1);
    exp_count = 10'd4;
    req_in    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("gate_rdy", 32'(rdy_out), 0);
    end
    do_reads(2);
    burst(4, 4, 1'b0, -1);
    check_eq("full_level", 32'(level_o), 512);
    do_reads(513);

    // Reset in mid-burst with committed data present
    burst(10, 10, 1'b0, -1);
    do_reads(1);
    exp_count = 10'd4;
    req_in    = 1'b1;
    step();
    valid_in = 1'b1;
    data_in  = 32'h55;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_rdy", 32'(rdy_out), 0);
    check_eq("arst_ack", 32'(ack_out), 0);
    check_eq("arst_empty", 32'(empty_o), 1);
    check_eq("arst_level", 32'(level_o), 0);
    check_eq("arst_underflow", 32'(underflow_o), 0);
    check_eq("arst_rd_data", rd_data_o, 0);
    valid_in = 1'b0;
    req_in   = 1'b0;
    model_q.delete();
    exp_acks  = 0;
    exp_nacks = 0;
    check_stats();
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_empty", 32'(empty_o), 1);
    burst(4, 4, 1'b0, -1);
    do_reads(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
